// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the power-sequencing scheduler.
package pwr_seq_pkg;

    localparam int unsigned CW_DEFAULT = 8;

    // Priority direction: on-requests pick lowest index, off-requests highest.
    localparam bit GNT_ON  = 1'b0;
    localparam bit GNT_OFF = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GRANT  = 2'd2,
        GAP    = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pwr_seq_prio_pick.sv
// One-hot priority pick: lowest index for GNT_ON, highest index for GNT_OFF.
module pwr_seq_prio_pick
    import pwr_seq_pkg::*;
#(
    parameter int unsigned N   = 2,
    parameter bit          DIR = GNT_ON
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] pick,
    output logic         valid
);

    logic        found;
    int unsigned idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (DIR == GNT_ON) ? i : (N - 1 - i);
            if (req[idx] && !found) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/pwr_seq_sched.sv
// Power-sequencing scheduler: serialises domain on/off sequences, enforces
// domain ordering and owns the DCDC enable with its settle delay.
module pwr_seq_sched
    import pwr_seq_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned CW     = CW_DEFAULT,
    parameter int unsigned RST_ON = 1
) (
    input  logic          i_aon_clk,
    input  logic          i_soc_pwr_on_rst,
    input  logic [N-1:0]  i_on_req,
    input  logic [N-1:0]  i_off_req,
    input  logic [N-1:0]  i_seq_done,
    input  logic [CW-1:0] i_settle_cycles,
    input  logic [CW-1:0] i_gap_cycles,
    output logic [N-1:0]  o_on_gnt,
    output logic [N-1:0]  o_off_gnt,
    output logic [N-1:0]  o_pwr_status,
    output logic          o_dcdc_enable,
    output logic          o_busy,
    output logic          o_err
);

    localparam logic [N-1:0] STATUS_RST = (RST_ON != 0) ? '1 : '0;
    localparam logic         DCDC_RST   = (RST_ON != 0);

    seq_state_e    state_q, state_d;
    logic [N-1:0]  on_gnt_q, on_gnt_d;
    logic [N-1:0]  off_gnt_q, off_gnt_d;
    logic [N-1:0]  status_q, status_d;
    logic          dcdc_q, dcdc_d;
    logic          err_q, err_d;
    logic          busy_q;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  on_elig, off_elig;
    logic [N-1:0]  on_pick, off_pick;
    logic          on_valid, off_valid;
    logic          prev_on, higher_on;
    logic          done_hit;
    logic [N-1:0]  gnt_vec;

    // Eligibility: on follows the domain below, off waits for all domains above.
    always_comb begin
        on_elig   = '0;
        off_elig  = '0;
        prev_on   = 1'b1;
        higher_on = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            on_elig[k] = i_on_req[k] & ~status_q[k] & prev_on;
            prev_on    = status_q[k];
        end
        for (int k = int'(N) - 1; k >= 0; k--) begin
            off_elig[k] = i_off_req[k] & status_q[k] & ~higher_on;
            higher_on   = higher_on | status_q[k];
        end
    end

    pwr_seq_prio_pick #(.N(N), .DIR(GNT_ON)) u_on_pick (
        .req   (on_elig),
        .pick  (on_pick),
        .valid (on_valid)
    );

    pwr_seq_prio_pick #(.N(N), .DIR(GNT_OFF)) u_off_pick (
        .req   (off_elig),
        .pick  (off_pick),
        .valid (off_valid)
    );

    assign gnt_vec  = on_gnt_q | off_gnt_q;
    assign done_hit = |(i_seq_done & gnt_vec);

    // State register
    always_ff @(posedge i_aon_clk) begin
        if (i_soc_pwr_on_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (on_valid) begin
                    if (!dcdc_q && (i_settle_cycles != '0)) state_d = SETTLE;
                    else                                     state_d = GRANT;
                end else if (off_valid) begin
                    state_d = GRANT;
                end
            end
            SETTLE: begin
                if (!on_valid)                state_d = IDLE;
                else if (cnt_q <= CW'(1))     state_d = GRANT;
            end
            GRANT: begin
                if (done_hit) state_d = (i_gap_cycles == '0) ? IDLE : GAP;
            end
            GAP: begin
                if (cnt_q <= CW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; registered below
    always_comb begin
        on_gnt_d  = on_gnt_q;
        off_gnt_d = off_gnt_q;
        status_d  = status_q;
        dcdc_d    = dcdc_q;
        cnt_d     = cnt_q;
        err_d     = |i_seq_done;
        case (state_q)
            IDLE: begin
                if (on_valid) begin
                    if (!dcdc_q) begin
                        dcdc_d = 1'b1;
                        cnt_d  = i_settle_cycles;
                        if (i_settle_cycles == '0) on_gnt_d = on_pick;
                    end else begin
                        on_gnt_d = on_pick;
                    end
                end else if (off_valid) begin
                    off_gnt_d = off_pick;
                end else if ((status_q == '0) && dcdc_q) begin
                    dcdc_d = 1'b0;
                end
            end
            SETTLE: begin
                if (on_valid) begin
                    if (cnt_q <= CW'(1)) on_gnt_d = on_pick;
                    else                 cnt_d    = cnt_q - CW'(1);
                end
            end
            GRANT: begin
                err_d = |(i_seq_done & ~gnt_vec);
                if (done_hit) begin
                    on_gnt_d  = '0;
                    off_gnt_d = '0;
                    status_d  = (status_q | on_gnt_q) & ~off_gnt_q;
                    cnt_d     = i_gap_cycles;
                end
            end
            GAP: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            default: ;
        endcase
    end

    // Registered outputs and counter
    always_ff @(posedge i_aon_clk) begin
        if (i_soc_pwr_on_rst) begin
            on_gnt_q  <= '0;
            off_gnt_q <= '0;
            status_q  <= STATUS_RST;
            dcdc_q    <= DCDC_RST;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            on_gnt_q  <= on_gnt_d;
            off_gnt_q <= off_gnt_d;
            status_q  <= status_d;
            dcdc_q    <= dcdc_d;
            err_q     <= err_d;
            busy_q    <= (state_d != IDLE);
            cnt_q     <= cnt_d;
        end
    end

    assign o_on_gnt      = on_gnt_q;
    assign o_off_gnt     = off_gnt_q;
    assign o_pwr_status  = status_q;
    assign o_dcdc_enable = dcdc_q;
    assign o_busy        = busy_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_pwr_seq_sched.sv
// Directed bench for pwr_seq_sched (N=2, CW=8, RST_ON=1).
module tb_pwr_seq_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] on_req, off_req, seq_done;
    logic [7:0] settle, gap;
    logic [1:0] on_gnt, off_gnt, pwr_status;
    logic       dcdc_en, busy, err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pwr_seq_sched #(.N(2), .CW(8), .RST_ON(1)) dut (
        .i_aon_clk        (clk),
        .i_soc_pwr_on_rst (rst),
        .i_on_req         (on_req),
        .i_off_req        (off_req),
        .i_seq_done       (seq_done),
        .i_settle_cycles  (settle),
        .i_gap_cycles     (gap),
        .o_on_gnt         (on_gnt),
        .o_off_gnt        (off_gnt),
        .o_pwr_status     (pwr_status),
        .o_dcdc_enable    (dcdc_en),
        .o_busy           (busy),
        .o_err            (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; on_req = 2'b00; off_req = 2'b00; seq_done = 2'b00;
        settle = 8'd3; gap = 8'd2;
        tick(); tick();
        n_chk++; if ({on_gnt, off_gnt} !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt: got %b exp 0000", {on_gnt, off_gnt}); end
        n_chk++; if (pwr_status !== 2'b11) begin n_fail++; $display("FAIL rst_status: got %b exp 11", pwr_status); end
        n_chk++; if ({dcdc_en, busy, err} !== 3'b100) begin n_fail++; $display("FAIL rst_ctrl: got %b exp 100", {dcdc_en, busy, err}); end
        rst = 1'b0;
        tick();
    endtask

    // Off ordering with G=2, including a mismatched done while 2'b10 is granted
    task automatic test_off_ordering();
        off_req = 2'b11;
        tick();
        n_chk++; if (off_gnt !== 2'b10) begin n_fail++; $display("FAIL off_first: got %b exp 10", off_gnt); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL off_busy: got %b exp 1", busy); end
        seq_done = 2'b01;
        tick();
        seq_done = 2'b00;
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_pulse: got %b exp 1", err); end
        n_chk++; if ({off_gnt, pwr_status} !== 4'b1011) begin n_fail++; $display("FAIL err_hold: got %b exp 1011", {off_gnt, pwr_status}); end
        tick();
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b exp 0", err); end
        seq_done = 2'b10;
        tick();
        seq_done = 2'b00;
        n_chk++; if ({off_gnt, pwr_status} !== 4'b0001) begin n_fail++; $display("FAIL off_done1: got %b exp 0001", {off_gnt, pwr_status}); end
        tick();
        n_chk++; if (off_gnt !== 2'b00) begin n_fail++; $display("FAIL off_gap_a: got %b exp 00", off_gnt); end
        tick();
        n_chk++; if (off_gnt !== 2'b00) begin n_fail++; $display("FAIL off_gap_b: got %b exp 00", off_gnt); end
        tick();
        n_chk++; if (off_gnt !== 2'b01) begin n_fail++; $display("FAIL off_second: got %b exp 01", off_gnt); end
        seq_done = 2'b01;
        tick();
        seq_done = 2'b00; off_req = 2'b00;
        n_chk++; if ({off_gnt, pwr_status, dcdc_en} !== 5'b00001) begin n_fail++; $display("FAIL off_done2: got %b exp 00001", {off_gnt, pwr_status, dcdc_en}); end
        tick(); tick();
        n_chk++; if (dcdc_en !== 1'b1) begin n_fail++; $display("FAIL dcdc_hold: got %b exp 1", dcdc_en); end
        tick();
        n_chk++; if ({dcdc_en, busy} !== 2'b00) begin n_fail++; $display("FAIL dcdc_off: got %b exp 00", {dcdc_en, busy}); end
    endtask

    task automatic test_dep_block();
        on_req = 2'b10;
        tick(); tick(); tick();
        n_chk++; if ({on_gnt, dcdc_en, busy} !== 4'b0000) begin n_fail++; $display("FAIL dep_block: got %b exp 0000", {on_gnt, dcdc_en, busy}); end
        on_req = 2'b00;
        tick();
    endtask

    // On ordering with S=3, then grant held after its request drops
    task automatic test_on_ordering();
        on_req = 2'b11;
        tick();
        n_chk++; if ({dcdc_en, on_gnt} !== 3'b100) begin n_fail++; $display("FAIL on_dcdc: got %b exp 100", {dcdc_en, on_gnt}); end
        tick(); tick();
        n_chk++; if (on_gnt !== 2'b00) begin n_fail++; $display("FAIL on_settle: got %b exp 00", on_gnt); end
        tick();
        n_chk++; if (on_gnt !== 2'b01) begin n_fail++; $display("FAIL on_first: got %b exp 01", on_gnt); end
        seq_done = 2'b01;
        tick();
        seq_done = 2'b00;
        n_chk++; if ({on_gnt, pwr_status} !== 4'b0001) begin n_fail++; $display("FAIL on_done1: got %b exp 0001", {on_gnt, pwr_status}); end
        tick(); tick();
        n_chk++; if (on_gnt !== 2'b00) begin n_fail++; $display("FAIL on_gap: got %b exp 00", on_gnt); end
        tick();
        n_chk++; if (on_gnt !== 2'b10) begin n_fail++; $display("FAIL on_second: got %b exp 10", on_gnt); end
        on_req = 2'b00;
        tick(); tick();
        n_chk++; if (on_gnt !== 2'b10) begin n_fail++; $display("FAIL no_abort: got %b exp 10", on_gnt); end
        seq_done = 2'b10;
        tick();
        seq_done = 2'b00;
        n_chk++; if ({on_gnt, pwr_status} !== 4'b0011) begin n_fail++; $display("FAIL on_done2: got %b exp 0011", {on_gnt, pwr_status}); end
        tick(); tick(); tick();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL on_idle: got %b exp 0", busy); end
    endtask

    // On and off eligible in the same cycle: on wins
    task automatic test_priority();
        off_req = 2'b10;
        tick();
        off_req = 2'b00;
        seq_done = 2'b10;
        tick();
        seq_done = 2'b00;
        n_chk++; if (pwr_status !== 2'b01) begin n_fail++; $display("FAIL prio_setup: got %b exp 01", pwr_status); end
        tick(); tick();
        on_req = 2'b10; off_req = 2'b01;
        tick();
        n_chk++; if ({on_gnt, off_gnt} !== 4'b1000) begin n_fail++; $display("FAIL prio_on_first: got %b exp 1000", {on_gnt, off_gnt}); end
        on_req = 2'b00; off_req = 2'b00;
        seq_done = 2'b10;
        tick();
        seq_done = 2'b00;
        tick(); tick();
        n_chk++; if ({pwr_status, busy} !== 3'b110) begin n_fail++; $display("FAIL prio_end: got %b exp 110", {pwr_status, busy}); end
    endtask

    // S=0, G=0: back-to-back grants and immediate DCDC-off / grant
    task automatic test_zero_delay();
        settle = 8'd0; gap = 8'd0;
        off_req = 2'b11;
        tick();
        n_chk++; if (off_gnt !== 2'b10) begin n_fail++; $display("FAIL z_off1: got %b exp 10", off_gnt); end
        seq_done = 2'b10;
        tick();
        seq_done = 2'b00;
        n_chk++; if ({off_gnt, pwr_status} !== 4'b0001) begin n_fail++; $display("FAIL z_done1: got %b exp 0001", {off_gnt, pwr_status}); end
        tick();
        n_chk++; if (off_gnt !== 2'b01) begin n_fail++; $display("FAIL z_off2: got %b exp 01", off_gnt); end
        off_req = 2'b00;
        seq_done = 2'b01;
        tick();
        seq_done = 2'b00;
        n_chk++; if ({pwr_status, dcdc_en} !== 3'b001) begin n_fail++; $display("FAIL z_done2: got %b exp 001", {pwr_status, dcdc_en}); end
        tick();
        n_chk++; if (dcdc_en !== 1'b0) begin n_fail++; $display("FAIL z_dcdc_off: got %b exp 0", dcdc_en); end
        on_req = 2'b01;
        tick();
        n_chk++; if ({dcdc_en, on_gnt} !== 3'b101) begin n_fail++; $display("FAIL z_on: got %b exp 101", {dcdc_en, on_gnt}); end
        on_req = 2'b00;
        seq_done = 2'b01;
        tick();
        seq_done = 2'b00;
        n_chk++; if (pwr_status !== 2'b01) begin n_fail++; $display("FAIL z_on_done: got %b exp 01", pwr_status); end
    endtask

    task automatic test_reset_mid();
        on_req = 2'b10;
        tick();
        n_chk++; if (on_gnt !== 2'b10) begin n_fail++; $display("FAIL mid_gnt: got %b exp 10", on_gnt); end
        rst = 1'b1;
        tick();
        n_chk++; if ({on_gnt, off_gnt, pwr_status, dcdc_en, busy, err} !== 9'b000011100) begin
            n_fail++; $display("FAIL mid_rst: got %b exp 000011100", {on_gnt, off_gnt, pwr_status, dcdc_en, busy, err});
        end
        rst = 1'b0; on_req = 2'b00;
        tick();
        n_chk++; if ({on_gnt, busy} !== 3'b000) begin n_fail++; $display("FAIL post_rst: got %b exp 000", {on_gnt, busy}); end
    endtask

    initial begin
        test_reset();
        test_off_ordering();
        test_dep_block();
        test_on_ordering();
        test_priority();
        test_zero_delay();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pwr_seq_sched.md
# pwr_seq_sched

Power-sequencing scheduler for the always-on power controller. It sits between the per-domain power FSMs and the shared DCDC regulator. Only one domain may run a power-on or power-off sequence at a time, which bounds inrush current. Domain dependencies are enforced: domain k powers on only after k-1 is on, and powers off only after all higher domains are off. The block also owns `o_dcdc_enable` and its settle delay.

## Interface
- `N`, default 2: number of power domains; domain 0 is the root.
- `CW`, default 8: width of the delay counters and delay inputs.
- `RST_ON`, default 1: if 1, all domains and the DCDC are considered on out of reset.

Ports:
- `i_aon_clk` in, 1: always-on clock. This is the only clock.
- `i_soc_pwr_on_rst` in, 1: reset. **Synchronous and active-high.**
- `i_on_req` in, N: level request from domain FSM k to start its power-on sequence.
- `i_off_req` in, N: level request from domain FSM k to start its power-off sequence.
- `i_seq_done` in, N: one-cycle pulse from domain FSM k when its granted sequence has completed.
- `i_settle_cycles` in, CW: DCDC settle time in cycles.
- `i_gap_cycles` in, CW: minimum idle time between consecutive grants.
- `o_on_gnt` out, N: one-hot power-on grant, held until done.
- `o_off_gnt` out, N: one-hot power-off grant, held until done.
- `o_pwr_status` out, N: bit k = 1 when domain k is on.
- `o_dcdc_enable` out, 1: regulator enable.
- `o_busy` out, 1: high whenever state ≠ IDLE.
- `o_err` out, 1: one-cycle pulse on an `i_seq_done` bit that does not match the current grant.

## Operation
- Reset values:
  - `o_on_gnt` = 0, `o_off_gnt` = 0, `o_busy` = 0, `o_err` = 0.
  - `o_pwr_status` = all ones if `RST_ON`, else 0.
  - `o_dcdc_enable` = `RST_ON`.
  - State = IDLE, counters = 0.
- Eligibility:
  - On-request k is eligible when `status[k]`=0 and (k=0 or `status[k-1]`=1).
  - Off-request k is eligible when `status[k]`=1 and `status[N-1:k+1]`=0.
  - Requests that are already satisfied are ignored, e.g. on-req for a domain that is already on.
- Selection in IDLE:
  - Any eligible on-request beats any eligible off-request, to minimise wakeup latency.
  - Among on-requests, the lowest index wins.
  - Among off-requests, the highest index wins.
  - If on and off are both requested for the same domain, only the eligible one is considered.
- States:
  - IDLE:
    - Eligible on-request and `o_dcdc_enable`=0: set `o_dcdc_enable`, load the counter with `i_settle_cycles`, go to SETTLE. If `i_settle_cycles`=0, go directly to GRANT instead.
    - Eligible on-request with the DCDC already on, or an eligible off-request: assert the grant, go to GRANT.
    - No eligible request, status all zero and `o_dcdc_enable`=1: clear `o_dcdc_enable`.
  - SETTLE:
    - Decrement the counter.
    - When it reaches 1, assert the on-grant for the request re-selected that cycle and go to GRANT.
    - If no on-request is eligible any more, return to IDLE. The DCDC stays on; IDLE's rule above turns it off.
  - GRANT:
    - Hold the grant even if its request drops; sequences are not abortable.
    - On `i_seq_done[g]`: drop the grant, set or clear `status[g]`, load the counter with `i_gap_cycles`.
    - Then go to GAP, or to IDLE if the gap is 0.
    - Any other `i_seq_done` bit pulses `o_err` and is otherwise ignored.
  - GAP: decrement the counter; go to IDLE when it reaches 1.
- `i_seq_done` outside GRANT pulses `o_err` and has no other effect.
- Counters are unsigned CW-bit and never wrap: a decrement at 0 is suppressed.
- Delay inputs are sampled only at load time.

## Timing
- All outputs are registered.
- Request eligible in IDLE at cycle t with the DCDC on: grant is high at t+1.
- DCDC off with settle S≥1: `o_dcdc_enable` is high at t+1, grant is high at t+S+1.
- `i_seq_done` at cycle d:
  - Grant is low and status is updated at d+1.
  - With gap G≥1, the next grant is high no earlier than d+G+2.
  - With G=0, the next grant is high no earlier than d+2.
- DCDC off: last off-done at d, so status is 0 at d+1; with no eligible on-request, `o_dcdc_enable` is low at d+G+2 (G=0: d+2).
- At most one bit across `o_on_gnt | o_off_gnt` is ever set.
- Reset asserted mid-sequence returns every output to its reset value at the next edge.

## Structure
- Package `pwr_seq_pkg`:
  - State enum `{IDLE, SETTLE, GRANT, GAP}`.
  - `GNT_ON`/`GNT_OFF` direction constant.
  - Default `CW`.
- Sub-module `pwr_seq_prio_pick`: combinational, parameterised by N and a direction bit. It returns a one-hot lowest- or highest-index pick plus a valid flag. It is instantiated twice, once for on-requests and once for off-requests.
- Expected size: ~200 lines of RTL.

## Test plan
- Off ordering:
  - Setup: N=2, `RST_ON`=1, G=2, `i_off_req`=2'b11.
  - Required: `o_off_gnt`=2'b10 first; after its done, no grant for 2 cycles; then 2'b01.
  - After the second done: status=0 and `o_dcdc_enable`=0 two cycles later.
- On ordering with settle:
  - Setup: from all-off, S=3, `i_on_req`=2'b11.
  - Required: `o_dcdc_enable` high at t+1, `o_on_gnt`=2'b01 at t+4; 2'b10 only after domain 0's done.
- Dependency block: with status=2'b00, `i_on_req`=2'b10 alone → no grant, DCDC stays off, `o_busy`=0.
- Priority and no abort:
  - On and off requests become eligible in the same cycle → the on-grant is issued first.
  - Dropping `i_on_req` while granted → the grant is held until `i_seq_done`.
- Error and reset:
  - `i_seq_done`=2'b01 while `o_off_gnt`=2'b10 → one-cycle `o_err` pulse; grant and status unchanged.
  - Reset asserted during GRANT → all outputs at reset values next edge.
- Zero delays: S=0, G=0 → grant one cycle after the request; back-to-back grants two cycles apart.
